inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
Write-side counterpart of the instruction memory: receives a byte stream (from a UART/debug bridge) and programs 32-bit instruction words into the instruction memory write port before the core runs. Holds the core in reset while loading and reports done or error. Sits between the boot/debug interface and the instruction memory, and drives the core's hold line.

Parameters:
DEPTH, 64, number of 32-bit words in instruction memory; valid word indices are 0..DEPTH-1
ADDR_W, 32, width of the byte address driven to the memory write port

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a load session when idle
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  one-cycle write strobe to instruction memory
wr_addr  output  ADDR_W  byte address, always word aligned (word_idx*4)
wr_data  output  32  assembled instruction word
cpu_hold  output  1  high while a session is active; holds the core in reset
done  output  1  sticky: last session completed successfully
error  output  1  sticky: last session aborted

Behaviour:
- Clocking: clk rising edge only; rst is synchronous, active-high.
- Reset: state IDLE; in_ready, wr_en, cpu_hold, done and error all 0; wr_addr and wr_data 0; counters 0. A reset mid-session aborts it immediately. Words already written remain in memory.
- Handshake: a byte transfers when in_valid && in_ready. in_ready is 1 only in LEN_LO, LEN_HI and DATA (and CSUM if enabled). The memory never back-pressures.
- Frame format: 2-byte little-endian word count N, then 4N data bytes. Each word is little-endian: first byte goes to bits [7:0].
- States:
  - IDLE: on start, go to LEN_LO; clear done and error; set cpu_hold=1.
  - LEN_LO: accept low byte of N; go to LEN_HI.
  - LEN_HI: accept high byte. If N==0, go to DONE. If N>DEPTH, go to ERR. Otherwise go to DATA with word_idx=0 and byte_idx=0.
  - DATA: accept bytes; byte_idx wraps 3 to 0. On the 4th byte, the next cycle drives wr_en=1 for exactly one cycle with wr_addr=word_idx*4 and wr_data=the assembled word. Write latency is 1 cycle after the 4th byte handshake.
  - DATA exit: after the write of word N-1, go to DONE (or CSUM if enabled). Bytes may keep streaming back-to-back during the write cycle.
  - DONE: done=1, cpu_hold=0, go to IDLE. done stays high until the next start or rst.
  - ERR: error=1, cpu_hold=0, go to IDLE. error is sticky until the next start or rst. No further writes are issued.
- start while cpu_hold=1 is ignored.
- Bytes offered in IDLE are not accepted (in_ready=0).
- word_idx never exceeds DEPTH-1. wr_addr never exceeds (DEPTH-1)*4.
- wr_addr and wr_data hold their last values when wr_en=0.

Optional Feature:
Macro INST_MEM_LOADER_CHECKSUM_EN.
- Defined: after the last data byte, state CSUM accepts one trailer byte and compares it to the XOR of all 4N data bytes. Match goes to DONE; mismatch goes to ERR. Words are still written as they arrive. When N==0, the trailer must be 0x00.
- Undefined: no CSUM state and no trailer byte; DATA goes directly to DONE.

Decomposition:
- Package inst_mem_loader_pkg: state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR), HDR_BYTES=2, BYTES_PER_WORD=4.
- One sub-module, word_assembler: byte shift register plus byte_idx counter. Emits a word_valid pulse and the 32-bit word. The FSM, address counter and checksum stay in the top level.

Test Plan:
- Load 2 words: start, stream 02 00 | 33 00 00 00 | 83 20 00 00. Expect wr_en at addr 0x0 with 0x00000033, then at addr 0x4 with 0x00002083; then done=1, cpu_hold=0, error=0.
- Zero length: stream 00 00. Expect no wr_en, done=1 two cycles after the last byte, cpu_hold dropped.
- Oversize: N=65 (41 00) with DEPTH=64. Expect error=1, no wr_en, and in_ready=0 afterwards.
- Stalls: in_valid toggled randomly across 14 words. Expect exactly 14 writes with correct addresses 0x0..0x34 and no duplicate strobes.
- Abort: assert rst after 6 data bytes. Expect all outputs 0 next cycle and no write for the partial word. A new start then loads cleanly.
- With INST_MEM_LOADER_CHECKSUM_EN: one word 13 00 00 00 with trailer 0x13 gives done=1; the same word with trailer 0x12 gives error=1, and the word is still written to addr 0x0.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Optional trailer checksum is enabled with INST_MEM_LOADER_CHECKSUM_EN.
package inst_mem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// Collects little-endian stream bytes into 32-bit words; pulses word_valid_o
// the cycle after the last byte of a word and holds word_o until the next one.
module inst_mem_loader_word_assembler
  import inst_mem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam int unsigned IdxW = $clog2(BYTES_PER_WORD);
  localparam int unsigned ShW  = 8 * (BYTES_PER_WORD - 1);

  logic [IdxW-1:0] idx_q, idx_d;
  logic [ShW-1:0]  shift_q, shift_d;
  logic [31:0]     word_q, word_d;
  logic            valid_q, valid_d;

  assign last_byte_o  = (idx_q == IdxW'(BYTES_PER_WORD - 1));
  assign word_valid_o = valid_q;
  assign word_o       = word_q;

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      idx_d = '0;
    end else if (byte_valid_i) begin
      if (last_byte_o) begin
        // Earlier bytes sit in the low positions: first byte ends up in [7:0].
        word_d  = {byte_i, shift_q};
        valid_d = 1'b1;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
      shift_d = {byte_i, shift_q[ShW-1:8]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Programs instruction memory from a length-prefixed byte stream while holding the core.
// Define INST_MEM_LOADER_CHECKSUM_EN to require an XOR trailer byte after the data.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  localparam state_e StAfterData = StCsum;
`else
  localparam state_e StAfterData = StDone;
`endif

  state_e            state_q, state_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [IdxW-1:0]   last_idx_q, last_idx_d;
  logic [IdxW-1:0]   word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic [15:0] len;
  logic        beat;
  logic        data_beat;
  logic        asm_clear;
  logic        asm_last;
  logic        asm_valid;
  logic [31:0] asm_word;

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  assign in_ready_o = (state_q == StLenLo) || (state_q == StLenHi) ||
                      (state_q == StData)  || (state_q == StCsum);
`else
  assign in_ready_o = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
`endif

  assign beat      = in_valid_i & in_ready_o;
  assign data_beat = beat & (state_q == StData);
  assign len       = {in_data_i, len_lo_q};

  inst_mem_loader_word_assembler u_word_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (asm_clear),
    .byte_valid_i (data_beat),
    .byte_i       (in_data_i),
    .last_byte_o  (asm_last),
    .word_valid_o (asm_valid),
    .word_o       (asm_word)
  );

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == StIdle && start_i) begin
      csum_d = '0;
    end else if (data_beat) begin
      csum_d = csum_q ^ in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    done_d     = done_q;
    error_d    = error_q;
    len_lo_d   = len_lo_q;
    last_idx_d = last_idx_q;
    word_idx_d = word_idx_q;
    wr_addr_d  = wr_addr_q;
    asm_clear  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StLenLo;
          hold_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          word_idx_d = '0;
          asm_clear  = 1'b1;
        end
      end
      StLenLo: begin
        if (beat) begin
          len_lo_d = in_data_i;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (beat) begin
          if (len == 16'd0) begin
            state_d = StAfterData;
          end else if (32'(len) > DEPTH) begin
            state_d = StErr;
          end else begin
            state_d    = StData;
            last_idx_d = IdxW'(len - 16'd1);
            word_idx_d = '0;
          end
        end
      end
      StData: begin
        // Address is latched alongside the word so both appear with the strobe.
        if (data_beat && asm_last) begin
          wr_addr_d = ADDR_W'({word_idx_q, 2'b00});
          if (word_idx_q == last_idx_q) begin
            state_d = StAfterData;
          end else begin
            word_idx_d = word_idx_q + IdxW'(1);
          end
        end
      end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      StCsum: begin
        if (beat) begin
          state_d = (in_data_i == csum_q) ? StDone : StErr;
        end
      end
`endif
      StDone: begin
        done_d  = 1'b1;
        hold_d  = 1'b0;
        state_d = StIdle;
      end
      StErr: begin
        error_d = 1'b1;
        hold_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      len_lo_q   <= '0;
      last_idx_q <= '0;
      word_idx_q <= '0;
      wr_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
      len_lo_q   <= len_lo_d;
      last_idx_q <= last_idx_d;
      word_idx_q <= word_idx_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  assign wr_en_o    = asm_valid;
  assign wr_data_o  = asm_word;
  assign wr_addr_o  = wr_addr_q;
  assign cpu_hold_o = hold_q;
  assign done_o     = done_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: table of single-word loads plus multi-cycle sequences.
// Trailer bytes are appended automatically when INST_MEM_LOADER_CHECKSUM_EN is defined.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_err = 0;

  logic [31:0] log_addr [256];
  logic [31:0] log_data [256];
  int          wr_cnt = 0;

  logic [7:0] frame [$];
  logic [7:0] last_xor;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs [5];

  inst_mem_loader #(
    .DEPTH  (64),
    .ADDR_W (32)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .cpu_hold_o (cpu_hold),
    .done_o     (done),
    .error_o    (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_cnt < 256) begin
        log_addr[wr_cnt] = wr_addr;
        log_data[wr_cnt] = wr_data;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_err++;
      $display("FAIL handshake_timeout: byte 0x%02h never accepted, in_ready=%0b", b, in_ready);
    end
  endtask

  task automatic run_frame(input bit stall, input bit trailer);
    logic [7:0] x = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < frame.size(); i++) begin
      if (stall && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
      send_byte(frame[i]);
      if (i >= 2) x = x ^ frame[i];
    end
    if (trailer) last_xor = x;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    if (trailer) send_byte(last_xor);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] exp;

    vecs[0] = '{8'h33, 8'h00, 8'h00, 8'h00, 32'h0000_0033};
    vecs[1] = '{8'h83, 8'h20, 8'h00, 8'h00, 32'h0000_2083};
    vecs[2] = '{8'h13, 8'h05, 8'hA0, 8'hFF, 32'hFFA0_0513};
    vecs[3] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEAD_BEEF};
    vecs[4] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h0403_0201};

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_cpu_hold", 32'(cpu_hold), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    rst = 1'b0;
    tick();

    // Bytes offered while idle are refused
    in_data  = 8'hAA;
    in_valid = 1'b1;
    repeat (3) tick();
    check("idle_in_ready", 32'(in_ready), 0);
    check("idle_cpu_hold", 32'(cpu_hold), 0);
    in_valid = 1'b0;

    // Two-word load with an ignored start pulse mid-session
    base = wr_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sess_in_ready", 32'(in_ready), 1);
    check("sess_cpu_hold", 32'(cpu_hold), 1);
    send_byte(8'h02);
    send_byte(8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    frame = '{8'h33, 8'h00, 8'h00, 8'h00, 8'h83, 8'h20, 8'h00, 8'h00};
    foreach (frame[i]) send_byte(frame[i]);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    send_byte(8'h33 ^ 8'h83 ^ 8'h20);
`endif
    check("two_hold_before_done", 32'(cpu_hold), 1);
    tick();
    check("two_count", 32'(wr_cnt - base), 2);
    check("two_addr0", log_addr[base], 32'h0);
    check("two_data0", log_data[base], 32'h0000_0033);
    check("two_addr1", log_addr[base+1], 32'h4);
    check("two_data1", log_data[base+1], 32'h0000_2083);
    check("two_done", 32'(done), 1);
    check("two_error", 32'(error), 0);
    check("two_hold", 32'(cpu_hold), 0);
    check("two_hold_addr", wr_addr, 32'h4);

    // Table of single-word loads
    for (int v = 0; v < 5; v++) begin
      base = wr_cnt;
      frame = '{8'h01, 8'h00, vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3};
      run_frame(1'b0, 1'b1);
      tick();
      check($sformatf("vec%0d_count", v), 32'(wr_cnt - base), 1);
      check($sformatf("vec%0d_addr", v), log_addr[base], 32'h0);
      check($sformatf("vec%0d_data", v), log_data[base], vecs[v].exp_data);
      check($sformatf("vec%0d_done", v), 32'(done), 1);
    end

    // Zero length: done appears two cycles after the last byte
    base = wr_cnt;
    frame = '{8'h00, 8'h00};
    run_frame(1'b0, 1'b1);
    check("zero_done_early", 32'(done), 0);
    tick();
    check("zero_done", 32'(done), 1);
    check("zero_hold", 32'(cpu_hold), 0);
    check("zero_writes", 32'(wr_cnt - base), 0);

    // Oversize length is rejected without writes
    base = wr_cnt;
    frame = '{8'h41, 8'h00};
    run_frame(1'b0, 1'b0);
    tick();
    check("over_error", 32'(error), 1);
    check("over_done", 32'(done), 0);
    check("over_hold", 32'(cpu_hold), 0);
    repeat (2) tick();
    check("over_in_ready", 32'(in_ready), 0);
    check("over_writes", 32'(wr_cnt - base), 0);

    // Fourteen words with random stalls
    base = wr_cnt;
    frame = '{8'h0E, 8'h00};
    for (int i = 0; i < 56; i++) frame.push_back(8'(i));
    run_frame(1'b1, 1'b1);
    tick();
    check("stall_count", 32'(wr_cnt - base), 14);
    for (int k = 0; k < 14; k++) begin
      exp = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      check($sformatf("stall_addr%0d", k), log_addr[base+k], 32'(4*k));
      check($sformatf("stall_data%0d", k), log_data[base+k], exp);
    end
    check("stall_done", 32'(done), 1);

    // Full depth: 64 words accepted, last address is the top word
    base = wr_cnt;
    frame = '{8'h40, 8'h00};
    for (int i = 0; i < 256; i++) frame.push_back(8'(i) ^ 8'h5A);
    run_frame(1'b0, 1'b1);
    tick();
    check("full_count", 32'(wr_cnt - base), 64);
    check("full_last_addr", log_addr[base+63], 32'hFC);
    check("full_last_data", log_data[base+63], 32'hA5A4_A7A6);
    check("full_done", 32'(done), 1);
    check("full_error", 32'(error), 0);

    // Reset after six data bytes
    base = wr_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    frame = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (frame[i]) send_byte(frame[i]);
    rst = 1'b1;
    tick();
    check("abort_in_ready", 32'(in_ready), 0);
    check("abort_wr_en", 32'(wr_en), 0);
    check("abort_hold", 32'(cpu_hold), 0);
    check("abort_done", 32'(done), 0);
    check("abort_error", 32'(error), 0);
    check("abort_wr_addr", wr_addr, 0);
    check("abort_wr_data", wr_data, 0);
    rst = 1'b0;
    tick();
    check("abort_writes", 32'(wr_cnt - base), 1);
    check("abort_word0", log_data[base], 32'h4433_2211);
    base = wr_cnt;
    frame = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_frame(1'b0, 1'b1);
    tick();
    check("reload_count", 32'(wr_cnt - base), 1);
    check("reload_addr", log_addr[base], 32'h0);
    check("reload_data", log_data[base], 32'h1234_5678);
    check("reload_done", 32'(done), 1);

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    // Explicit trailers: matching then mismatching
    base = wr_cnt;
    frame = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run_frame(1'b0, 1'b0);
    tick();
    check("csum_ok_done", 32'(done), 1);
    check("csum_ok_error", 32'(error), 0);
    base = wr_cnt;
    frame = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    run_frame(1'b0, 1'b0);
    tick();
    check("csum_bad_error", 32'(error), 1);
    check("csum_bad_done", 32'(done), 0);
    check("csum_bad_count", 32'(wr_cnt - base), 1);
    check("csum_bad_addr", log_addr[base], 32'h0);
    check("csum_bad_data", log_data[base], 32'h0000_0013);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
